spi_slave: RTL and testbench
============================

// Module: spi_slave
// PURPOSE
// - SPI responder for the spi_master; the other end of the same 4-wire link (sclk, cs, mosi, miso).
// - Oversamples sclk/cs/mosi in the local mclk domain. Deserialises mosi into rx words and serialises tx words onto miso.
// - Parallel side is a register-style interface for a local host: one-word tx holding buffer and one-word rx holding buffer.
// - Bit order is LSB first, matching the master's {miso,shift_reg[7:1]} shift.
// PARAMETERS
// - DATA_W       8   word width, bits per frame
// - SYNC_STAGES  2   synchroniser flops on sclk, cs, mosi (>=2)
// PORTS
// - mclk        in   1       system clock; sole clock of the block
// - reset       in   1       asynchronous, active-high reset
// - sclk        in   1       SPI clock from master, async to mclk
// - cs          in   1       chip select from master, active-low
// - mosi        in   1       serial data from master
// - miso        out  1       serial data to master
// - miso_oe     out  1       1 while selected (cs low), for pad tristate
// - tx_data     in   DATA_W  word to send in the next frame
// - tx_valid    in   1       tx_data write strobe
// - tx_ready    out  1       tx holding buffer empty
// - rx_data     out  DATA_W  last fully received word
// - rx_valid    out  1       rx_data holds an unread word
// - rx_ack      in   1       host consumed rx_data; clears rx_valid
// - rx_overrun  out  1       1-cycle pulse: word completed while rx_valid=1
// - tx_underrun out  1       1-cycle pulse: frame started with tx buffer empty
// - frame_err   out  1       1-cycle pulse: cs deasserted mid-word
// BEHAVIOUR
// - Reset values: miso=0, miso_oe=0, tx_ready=1, rx_data=0, rx_valid=0, all pulses=0, state=IDLE, bit_cnt=0.
// - Reset mid-frame aborts immediately and drops all buffered data.
// - Synchronisation and edges:
//   - sclk, cs and mosi pass through SYNC_STAGES flops.
//   - sclk_rise/sclk_fall and cs_fall/cs_rise are single-cycle edge flags on the synced signals.
//   - The master holds each sclk phase >= 2 mclk cycles.
// - Timing: master launches mosi on sclk rise and samples miso on sclk rise. The slave samples mosi on sclk_fall and launches the next miso bit on the same sclk_fall.
// - tx buffer: tx_valid with tx_ready=1 latches tx_data and drops tx_ready. tx_valid with tx_ready=0 is ignored.
// - FSM states: IDLE, SHIFT.
// - IDLE -> SHIFT on cs_fall:
//   - Shift register loads the tx buffer and tx_ready returns to 1.
//   - If the buffer is empty, the shift register loads 0 and tx_underrun pulses.
//   - bit_cnt=0 and miso_oe=1.
//   - miso = shift reg bit0 on the next cycle.
// - SHIFT, on sclk_fall:
//   - rx_shift <= {mosi_s, rx_shift[DATA_W-1:1]}.
//   - tx shift register shifts right.
//   - miso <= next bit.
//   - bit_cnt++.
// - SHIFT, when bit_cnt reaches DATA_W-1 and sclk_fall occurs (word complete):
//   - rx_data <= the assembled word and rx_valid=1 on the next cycle.
//   - If rx_valid was already 1: rx_data is overwritten and rx_overrun pulses.
//   - bit_cnt wraps to 0 and the tx buffer reloads (same underrun rule) for back-to-back words within one cs-low.
// - Latency: rx_valid rises SYNC_STAGES+2 mclk cycles after the raw sclk falling edge of the last bit.
// - SHIFT -> IDLE on cs_rise:
//   - miso=0 and miso_oe=0.
//   - If bit_cnt != 0: partial word discarded, frame_err pulses, no rx_valid.
// - rx_ack clears rx_valid.
// - rx_ack and a word completion in the same cycle: completion wins (rx_valid stays 1, no overrun).
// - sclk edges while in IDLE are ignored.
// - cs_fall and cs_rise are never both present in one cycle, because the synchroniser guarantees it.
// STRUCTURE
// - spi_pkg: state localparams (IDLE=1'b0, SHIFT=1'b1) and default DATA_W.
// - Sub-module spi_sync: SYNC_STAGES-deep synchroniser plus rise/fall edge detector, instantiated once per input (sclk, cs, mosi; mosi edges unused).
// - Top level holds the FSM, bit counter, tx/rx shift registers and holding buffers.
// TESTING
// - Single word:
//   - Stimulus: tx_data=8'hA5 preloaded; master sends 8'h3C with sclk=mclk/8.
//   - Response: miso bits LSB-first 1,0,1,0,0,1,0,1; rx_data=8'h3C; rx_valid=1; tx_ready=1.
// - Back-to-back words:
//   - Stimulus: tx 8'h01 then 8'h02 written during the first word; master sends 8'hF0, 8'h0F under one cs-low.
//   - Response: two rx completions; miso carries 01 then 02; no underrun.
// - Overrun:
//   - Stimulus: two words received with no rx_ack.
//   - Response: rx_overrun pulses once; rx_data = second word.
// - Underrun:
//   - Stimulus: cs_fall with tx buffer empty.
//   - Response: tx_underrun pulse; miso=0 for all 8 bits.
// - Abort:
//   - Stimulus: cs deasserted after 3 bits.
//   - Response: frame_err pulse; rx_valid stays 0; next full frame receives correctly.
// - Reset:
//   - Stimulus: reset asserted mid-word.
//   - Response: all outputs at reset values within 0 cycles (async); next frame is clean.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI responder: FSM state encoding and default sizes.
package spi_pkg;
  localparam int DATA_W_DEF      = 8;
  localparam int SYNC_STAGES_DEF = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;
endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchroniser for one async input plus single-cycle rise/fall flags.
// Latency STAGES cycles to q_o, edge flags valid in the cycle q_o changes; no backpressure.
module spi_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic mclk,
  input  logic reset,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);
  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign q_o    = sync_q[STAGES-1];
  assign rise_o = sync_q[STAGES-1] & ~prev_q;
  assign fall_o = ~sync_q[STAGES-1] & prev_q;
endmodule

// File: rtl/spi_slave.sv
// SPI responder, LSB first: mosi sampled and miso launched on synced sclk fall.
// rx_valid rises SYNC_STAGES+2 cycles after the last raw sclk fall; no backpressure, overrun/underrun pulse instead.
module spi_slave
  import spi_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic              mclk,
  input  logic              reset,
  input  logic              sclk,
  input  logic              cs,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ack,
  output logic              rx_overrun,
  output logic              tx_underrun,
  output logic              frame_err
);
  localparam int               CNT_W    = (DATA_W > 2) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  logic sclk_s, sclk_rise, sclk_fall;
  logic cs_s, cs_rise, cs_fall;
  logic mosi_s, mosi_rise, mosi_fall;
  logic unused_sync_outputs;

  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .mclk(mclk), .reset(reset), .d_i(sclk),
    .q_o(sclk_s), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );

  // cs idles high, so its synchroniser resets high to avoid a false select.
  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .mclk(mclk), .reset(reset), .d_i(cs),
    .q_o(cs_s), .rise_o(cs_rise), .fall_o(cs_fall)
  );

  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .mclk(mclk), .reset(reset), .d_i(mosi),
    .q_o(mosi_s), .rise_o(mosi_rise), .fall_o(mosi_fall)
  );

  assign unused_sync_outputs = ^{sclk_s, cs_s, mosi_rise, mosi_fall};

  state_e            state_q;
  logic [CNT_W-1:0]  bit_cnt_q;
  logic [DATA_W-1:0] tx_shift_q, rx_shift_q;
  logic              miso_q, miso_oe_q, done_q, frame_err_q, under_pend_q;

  logic [DATA_W-1:0] tx_buf_q, tx_buf_d;
  logic              tx_ready_q, tx_ready_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              rx_overrun_q, tx_underrun_q;

  logic              start, wrap, load, underrun;
  logic [DATA_W-1:0] load_word;

  assign start     = (state_q == IDLE) && cs_fall;
  assign wrap      = (state_q == SHIFT) && !cs_rise && sclk_fall && (bit_cnt_q == LAST_BIT);
  assign load      = start || wrap;
  assign load_word = tx_ready_q ? '0 : tx_buf_q;

  // A reload at word end only counts as an underrun once the master actually
  // clocks the next word; a frame that simply ends there is not an error.
  assign underrun  = (start && tx_ready_q) ||
                     ((state_q == SHIFT) && !cs_rise && sclk_rise && under_pend_q);

  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      tx_shift_q   <= '0;
      rx_shift_q   <= '0;
      miso_q       <= 1'b0;
      miso_oe_q    <= 1'b0;
      done_q       <= 1'b0;
      frame_err_q  <= 1'b0;
      under_pend_q <= 1'b0;
    end else begin
      done_q      <= 1'b0;
      frame_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cs_fall) begin
            state_q      <= SHIFT;
            bit_cnt_q    <= '0;
            tx_shift_q   <= load_word;
            miso_q       <= load_word[0];
            miso_oe_q    <= 1'b1;
            under_pend_q <= 1'b0;
          end
        end
        SHIFT: begin
          if (cs_rise) begin
            state_q      <= IDLE;
            miso_q       <= 1'b0;
            miso_oe_q    <= 1'b0;
            bit_cnt_q    <= '0;
            under_pend_q <= 1'b0;
            frame_err_q  <= (bit_cnt_q != '0);
          end else begin
            if (sclk_rise) begin
              under_pend_q <= 1'b0;
            end
            if (sclk_fall) begin
              rx_shift_q <= {mosi_s, rx_shift_q[DATA_W-1:1]};
              if (bit_cnt_q == LAST_BIT) begin
                bit_cnt_q    <= '0;
                done_q       <= 1'b1;
                tx_shift_q   <= load_word;
                miso_q       <= load_word[0];
                under_pend_q <= tx_ready_q;
              end else begin
                bit_cnt_q  <= bit_cnt_q + CNT_W'(1);
                tx_shift_q <= tx_shift_q >> 1;
                miso_q     <= tx_shift_q[1];
              end
            end
          end
        end
      endcase
    end
  end

  always_comb begin
    tx_buf_d   = tx_buf_q;
    tx_ready_d = tx_ready_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    if (load) begin
      tx_ready_d = 1'b1;
    end
    if (tx_valid && tx_ready_q) begin
      tx_buf_d   = tx_data;
      tx_ready_d = 1'b0;
    end
    // A completing word beats a simultaneous host acknowledge.
    if (done_q) begin
      rx_data_d  = rx_shift_q;
      rx_valid_d = 1'b1;
    end else if (rx_ack) begin
      rx_valid_d = 1'b0;
    end
  end

  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      tx_buf_q      <= '0;
      tx_ready_q    <= 1'b1;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      rx_overrun_q  <= 1'b0;
      tx_underrun_q <= 1'b0;
    end else begin
      tx_buf_q      <= tx_buf_d;
      tx_ready_q    <= tx_ready_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      rx_overrun_q  <= done_q && rx_valid_q && !rx_ack;
      tx_underrun_q <= underrun;
    end
  end

  assign miso        = miso_q;
  assign miso_oe     = miso_oe_q;
  assign tx_ready    = tx_ready_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign rx_overrun  = rx_overrun_q;
  assign tx_underrun = tx_underrun_q;
  assign frame_err   = frame_err_q;
endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: directed vector table, hand-written multi-cycle sequences, then random frames vs a word-level model.
module tb_spi_slave;
  logic       mclk, reset, sclk, cs, mosi, miso, miso_oe;
  logic [7:0] tx_data, rx_data;
  logic       tx_valid, tx_ready, rx_valid, rx_ack, rx_overrun, tx_underrun, frame_err;

  spi_slave #(.DATA_W(8), .SYNC_STAGES(2)) dut (
    .mclk(mclk), .reset(reset), .sclk(sclk), .cs(cs), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ack(rx_ack),
    .rx_overrun(rx_overrun), .tx_underrun(tx_underrun), .frame_err(frame_err)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  int vectors = 0;
  int miscompares = 0;
  int cyc_cnt = 0;
  int n_under = 0, n_over = 0, n_ferr = 0;
  int t_fall = 0, t_rv = 0;
  logic rv_prev = 1'b0;
  logic [7:0] got_q[$];

  always @(posedge mclk) cyc_cnt <= cyc_cnt + 1;

  // Pulse counters and a log of every rx word the host side gets to see.
  always @(negedge mclk) begin
    if (tx_underrun) n_under++;
    if (rx_overrun) n_over++;
    if (frame_err) n_ferr++;
    if ((rx_valid && !rv_prev) || rx_overrun) begin
      got_q.push_back(rx_data);
      t_rv = cyc_cnt;
    end
    rv_prev = rx_valid;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge mclk);
    #1;
  endtask

  task automatic write_tx(input logic [7:0] d);
    tx_data = d; tx_valid = 1'b1; cyc(1);
    tx_valid = 1'b0; cyc(1);
  endtask

  task automatic ack_rx();
    rx_ack = 1'b1; cyc(1);
    rx_ack = 1'b0; cyc(1);
  endtask

  // Master side: mosi launched and miso sampled on sclk rise, each phase 4 mclk.
  task automatic xfer(input int nbits, input logic [23:0] mo, input bit raise_cs,
                      output logic [23:0] mi);
    mi = '0;
    cs = 1'b0; cyc(6);
    for (int i = 0; i < nbits; i++) begin
      sclk = 1'b1; mosi = mo[i]; mi[i] = miso;
      cyc(4);
      sclk = 1'b0; t_fall = cyc_cnt;
      cyc(4);
    end
    if (raise_cs) begin
      cs = 1'b1; mosi = 1'b0;
      cyc(8);
    end
  endtask

  task automatic do_frame(input bit pre, input logic [7:0] txw, input bit pre2,
                          input logic [7:0] txw2, input logic [7:0] mo, input int nb,
                          input string tag, output logic [7:0] mi,
                          output int dun, output int dov, output int dfe);
    int u0, o0, f0;
    logic [23:0] mi24;
    if (pre) begin
      write_tx(txw);
      chk({tag, "_tx_ready_after_write"}, 32'(tx_ready), 32'd0);
    end
    if (pre2) write_tx(txw2);
    u0 = n_under; o0 = n_over; f0 = n_ferr;
    xfer(nb, {16'h0, mo}, 1'b1, mi24);
    mi = mi24[7:0];
    dun = n_under - u0; dov = n_over - o0; dfe = n_ferr - f0;
  endtask

  task automatic chk_frame(input string tag, input logic [7:0] mi, input logic [7:0] e_mi,
                           input logic [7:0] e_rx, input bit e_rv,
                           input int dun, input int e_un, input int dov, input int e_ov,
                           input int dfe, input int e_fe);
    chk({tag, "_miso"}, 32'(mi), 32'(e_mi));
    chk({tag, "_rx_data"}, 32'(rx_data), 32'(e_rx));
    chk({tag, "_rx_valid"}, 32'(rx_valid), 32'(e_rv));
    chk({tag, "_tx_ready"}, 32'(tx_ready), 32'd1);
    chk({tag, "_miso_oe_idle"}, 32'(miso_oe), 32'd0);
    chk({tag, "_underrun"}, 32'(dun), 32'(e_un));
    chk({tag, "_overrun"}, 32'(dov), 32'(e_ov));
    chk({tag, "_frame_err"}, 32'(dfe), 32'(e_fe));
  endtask

  typedef struct {
    bit         pre;
    logic [7:0] txw;
    bit         pre2;
    logic [7:0] txw2;
    logic [7:0] mo;
    int         nb;
    bit         ack;
    logic [7:0] e_mi;
    logic [7:0] e_rx;
    bit         e_rv;
    int         e_un;
    int         e_ov;
    int         e_fe;
  } vec_t;

  vec_t tbl[5];

  initial begin
    logic [7:0]  mi, txw, txw2, mo, sendw, e_mi, m_tx, m_rx;
    logic [23:0] mi24;
    bit          pre, pre2, ak, m_txv, m_rxv;
    int          nb, dun, dov, dfe, e_un, e_ov, e_fe, u0, o0, k;

    tbl[0] = '{1'b1, 8'hA5, 1'b0, 8'h00, 8'h3C, 8, 1'b0, 8'hA5, 8'h3C, 1'b1, 0, 0, 0};
    tbl[1] = '{1'b1, 8'h96, 1'b0, 8'h00, 8'hC3, 8, 1'b1, 8'h96, 8'hC3, 1'b1, 0, 1, 0};
    tbl[2] = '{1'b0, 8'h00, 1'b0, 8'h00, 8'h5A, 8, 1'b1, 8'h00, 8'h5A, 1'b1, 1, 0, 0};
    tbl[3] = '{1'b1, 8'h77, 1'b0, 8'h00, 8'hFF, 3, 1'b0, 8'h07, 8'h5A, 1'b0, 0, 0, 1};
    tbl[4] = '{1'b1, 8'h81, 1'b1, 8'h7E, 8'hE7, 8, 1'b1, 8'h81, 8'hE7, 1'b1, 0, 0, 0};

    reset = 1'b1; sclk = 1'b0; cs = 1'b1; mosi = 1'b0;
    tx_data = '0; tx_valid = 1'b0; rx_ack = 1'b0;
    cyc(3);
    reset = 1'b0;
    cyc(3);
    chk("reset_miso", 32'(miso), 32'd0);
    chk("reset_miso_oe", 32'(miso_oe), 32'd0);
    chk("reset_tx_ready", 32'(tx_ready), 32'd1);
    chk("reset_rx_data", 32'(rx_data), 32'd0);
    chk("reset_rx_valid", 32'(rx_valid), 32'd0);
    chk("reset_pulses", 32'(n_under + n_over + n_ferr), 32'd0);

    for (int i = 0; i < 5; i++) begin
      do_frame(tbl[i].pre, tbl[i].txw, tbl[i].pre2, tbl[i].txw2, tbl[i].mo, tbl[i].nb,
               $sformatf("vec%0d", i), mi, dun, dov, dfe);
      chk_frame($sformatf("vec%0d", i), mi, tbl[i].e_mi, tbl[i].e_rx, tbl[i].e_rv,
                dun, tbl[i].e_un, dov, tbl[i].e_ov, dfe, tbl[i].e_fe);
      if (i == 0) chk("rx_valid_latency", 32'(t_rv - t_fall), 32'd4);
      if (tbl[i].ack) ack_rx();
    end

    // Back-to-back words under one cs-low, next tx word written mid-frame.
    got_q.delete();
    write_tx(8'h01);
    u0 = n_under; o0 = n_over;
    fork
      xfer(16, {8'h00, 8'h0F, 8'hF0}, 1'b1, mi24);
      begin
        k = 0;
        while (!miso_oe && k < 200) begin cyc(1); k++; end
        chk("b2b_selected", 32'(miso_oe), 32'd1);
        write_tx(8'h02);
        k = 0;
        while (!rx_valid && k < 400) begin cyc(1); k++; end
        chk("b2b_first_valid", 32'(rx_valid), 32'd1);
        ack_rx();
      end
    join
    chk("b2b_miso", 32'(mi24[15:0]), 32'h0201);
    chk("b2b_rx_count", 32'(got_q.size()), 32'd2);
    if (got_q.size() >= 2) begin
      chk("b2b_rx_word0", 32'(got_q[0]), 32'hF0);
      chk("b2b_rx_word1", 32'(got_q[1]), 32'h0F);
    end
    chk("b2b_underrun", 32'(n_under - u0), 32'd0);
    chk("b2b_overrun", 32'(n_over - o0), 32'd0);
    chk("b2b_rx_data", 32'(rx_data), 32'h0F);
    ack_rx();

    // Reset in the middle of a word, then a clean frame.
    write_tx(8'h33);
    xfer(3, 24'h5, 1'b0, mi24);
    sclk = 1'b1; mosi = 1'b1;
    cyc(2);
    reset = 1'b1;
    #1;
    chk("midrst_miso", 32'(miso), 32'd0);
    chk("midrst_miso_oe", 32'(miso_oe), 32'd0);
    chk("midrst_tx_ready", 32'(tx_ready), 32'd1);
    chk("midrst_rx_data", 32'(rx_data), 32'd0);
    chk("midrst_rx_valid", 32'(rx_valid), 32'd0);
    sclk = 1'b0; cs = 1'b1; mosi = 1'b0;
    cyc(4);
    reset = 1'b0;
    cyc(4);
    do_frame(1'b1, 8'h44, 1'b0, 8'h00, 8'h99, 8, "postrst", mi, dun, dov, dfe);
    chk_frame("postrst", mi, 8'h44, 8'h99, 1'b1, dun, 0, dov, 0, dfe, 0);
    ack_rx();

    // Random frames against a word-level model of the two holding buffers.
    m_txv = 1'b0; m_tx = '0; m_rxv = 1'b0; m_rx = 8'h99;
    for (int r = 0; r < 40; r++) begin
      pre  = ($urandom_range(0, 1) == 1);
      pre2 = pre && ($urandom_range(0, 3) == 0);
      txw  = 8'($urandom);
      txw2 = 8'($urandom);
      mo   = 8'($urandom);
      nb   = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 7)) : 8;
      ak   = ($urandom_range(0, 1) == 1);

      if (pre && !m_txv) begin m_txv = 1'b1; m_tx = txw; end
      if (m_txv) begin sendw = m_tx; m_txv = 1'b0; e_un = 0; end
      else begin sendw = 8'h00; e_un = 1; end
      e_mi = '0;
      for (int b = 0; b < nb; b++) e_mi[b] = sendw[b];
      e_ov = 0; e_fe = 0;
      if (nb == 8) begin e_ov = m_rxv ? 1 : 0; m_rxv = 1'b1; m_rx = mo; end
      else e_fe = 1;

      do_frame(pre, txw, pre2, txw2, mo, nb, $sformatf("rnd%0d", r), mi, dun, dov, dfe);
      chk_frame($sformatf("rnd%0d", r), mi, e_mi, m_rx, m_rxv, dun, e_un, dov, e_ov, dfe, e_fe);
      if (ak) begin ack_rx(); m_rxv = 1'b0; end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
